// File: rtl/ppu_pkg.sv
// Shared PPU definitions: control-word bit positions, opcodes, and the
// destination-register decode used by the hazard and forwarding logic.
package ppu_pkg;

  localparam int CTRL_W = 17;

  localparam int CTRL_SRC_SEL_LSB  = 14;
  localparam int CTRL_ALU_OP_LSB   = 11;
  localparam int CTRL_LOAD         = 10;
  localparam int CTRL_RF_EN        = 9;
  localparam int CTRL_BRANCH       = 8;
  localparam int CTRL_JUMP         = 7;
  localparam int CTRL_MEM_SIZE_LSB = 5;
  localparam int CTRL_MEM_RW       = 4;
  localparam int CTRL_MEM_SE       = 3;
  localparam int CTRL_HI_EN        = 2;
  localparam int CTRL_LO_EN        = 1;
  localparam int CTRL_MEM_EN       = 0;

  localparam logic [5:0] R_TYPE = 6'b000000;
  localparam logic [5:0] JAL_OP = 6'b000011;
  localparam logic [5:0] SB_OP  = 6'b101000;
  localparam logic [5:0] LBU_OP = 6'b100100;

  // JAL links into r31; R-type writes rd; everything else writes rt.
  function automatic logic [4:0] dest_of(input logic [5:0] opcode,
                                         input logic [4:0] rt,
                                         input logic [4:0] rd);
    if (opcode == R_TYPE)      dest_of = rd;
    else if (opcode == JAL_OP) dest_of = 5'd31;
    else                       dest_of = rt;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational destination/source decode for the ID instruction and the
// load-use compare against the instruction currently in EX.
module load_use_detect
  import ppu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  input  logic       ex_valid,
  input  logic       ex_load,
  input  logic [4:0] ex_dest,
  output logic [4:0] id_dest,
  output logic       uses_rt,
  output logic       hazard
);

  assign id_dest = dest_of(opcode, rt, rd);
  assign uses_rt = (opcode == R_TYPE) || (opcode == SB_OP);

  // r0 is hard-wired zero, so a load into it never produces a dependency.
  assign hazard = ex_valid && ex_load && (ex_dest != 5'd0) &&
                  ((ex_dest == rs) || (uses_rt && (ex_dest == rt)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, external freeze,
// flush, and a saturating count of hazard bubbles.
module id_ex_stage
  import ppu_pkg::*;
#(
  parameter int CTRL_W = ppu_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [31:0]       id_instr,
  input  logic [31:0]       id_pc,
  input  logic [31:0]       id_rs_val,
  input  logic [31:0]       id_rt_val,
  input  logic              ext_stall,
  input  logic              flush,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_rs_val,
  output logic [31:0]       ex_rt_val,
  output logic [15:0]       ex_imm16,
  output logic [4:0]        ex_sa,
  output logic [4:0]        ex_dest,
  output logic              ex_valid,
  output logic              ifid_hold,
  output logic              hazard,
  output logic [CNT_W-1:0]  bubble_count
);

  logic [CTRL_W-1:0] ctrl_reg;
  logic [31:0]       pc_reg;
  logic [31:0]       rs_val_reg;
  logic [31:0]       rt_val_reg;
  logic [15:0]       imm16_reg;
  logic [4:0]        sa_reg;
  logic [4:0]        dest_reg;
  logic              valid_reg;
  logic [CNT_W-1:0]  bubble_count_reg;
  logic [4:0]        id_dest;
  logic              uses_rt;

  load_use_detect u_detect (
    .opcode   (id_instr[31:26]),
    .rs       (id_instr[25:21]),
    .rt       (id_instr[20:16]),
    .rd       (id_instr[15:11]),
    .ex_valid (valid_reg),
    .ex_load  (ctrl_reg[CTRL_LOAD]),
    .ex_dest  (dest_reg),
    .id_dest  (id_dest),
    .uses_rt  (uses_rt),
    .hazard   (hazard)
  );

  // A flushed instruction is discarded anyway, so there is nothing to hold for.
  assign ifid_hold = ext_stall || (hazard && !flush);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_reg         <= '0;
      pc_reg           <= '0;
      rs_val_reg       <= '0;
      rt_val_reg       <= '0;
      imm16_reg        <= '0;
      sa_reg           <= '0;
      dest_reg         <= '0;
      valid_reg        <= 1'b0;
      bubble_count_reg <= '0;
    end else if (!ext_stall) begin
      if (flush || hazard) begin
        ctrl_reg   <= '0;
        pc_reg     <= '0;
        rs_val_reg <= '0;
        rt_val_reg <= '0;
        imm16_reg  <= '0;
        sa_reg     <= '0;
        dest_reg   <= '0;
        valid_reg  <= 1'b0;
      end else begin
        ctrl_reg   <= id_ctrl;
        pc_reg     <= id_pc;
        rs_val_reg <= id_rs_val;
        rt_val_reg <= id_rt_val;
        imm16_reg  <= id_instr[15:0];
        sa_reg     <= id_instr[10:6];
        dest_reg   <= id_dest;
        valid_reg  <= 1'b1;
      end
      // Only bubbles caused by the hazard itself are counted, not flushes.
      if (!flush && hazard && (bubble_count_reg != '1))
        bubble_count_reg <= bubble_count_reg + 1'b1;
    end
  end

  assign ex_ctrl      = ctrl_reg;
  assign ex_pc        = pc_reg;
  assign ex_rs_val    = rs_val_reg;
  assign ex_rt_val    = rt_val_reg;
  assign ex_imm16     = imm16_reg;
  assign ex_sa        = sa_reg;
  assign ex_dest      = dest_reg;
  assign ex_valid     = valid_reg;
  assign bubble_count = bubble_count_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; a second 4-bit-counter instance shares the
// stimulus so bubble-count saturation can be observed.
module tb_id_ex_stage;

  localparam int CW = 17;

  // Hand-encoded MIPS instructions
  localparam logic [31:0] I_ADDIU_R5  = 32'h2425_0010; // addiu r5,r1,0x10
  localparam logic [31:0] I_SLL_R3    = 32'h0002_1940; // sll r3,r2,5
  localparam logic [31:0] I_LBU_R3    = 32'h9023_0000; // lbu r3,0(r1)
  localparam logic [31:0] I_SUBU_R4   = 32'h0062_2023; // subu r4,r3,r2
  localparam logic [31:0] I_LBU_R0    = 32'h9020_0000; // lbu r0,0(r1)
  localparam logic [31:0] I_SUBU_R0   = 32'h0002_2023; // subu r4,r0,r2
  localparam logic [31:0] I_ADDIU_R3  = 32'h24E3_0001; // addiu r3,r7,1
  localparam logic [31:0] I_SB_R3     = 32'hA023_0000; // sb r3,0(r1)
  localparam logic [31:0] I_JAL       = 32'h0C00_0000; // jal 0

  localparam logic [CW-1:0] C_ADDIU = 17'h1_2200;
  localparam logic [CW-1:0] C_LBU   = 17'h0_0669;
  localparam logic [CW-1:0] C_SUBU  = 17'h0_A200;
  localparam logic [CW-1:0] C_SB    = 17'h0_0031;
  localparam logic [CW-1:0] C_JAL   = 17'h0_0280;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] id_ctrl;
  logic [31:0]   id_instr, id_pc, id_rs_val, id_rt_val;
  logic          ext_stall, flush;

  logic [CW-1:0] ex_ctrl;
  logic [31:0]   ex_pc, ex_rs_val, ex_rt_val;
  logic [15:0]   ex_imm16;
  logic [4:0]    ex_sa, ex_dest;
  logic          ex_valid, ifid_hold, hazard;
  logic [15:0]   bubble_count;

  logic [CW-1:0] s_ctrl;
  logic [31:0]   s_pc, s_rs_val, s_rt_val;
  logic [15:0]   s_imm16;
  logic [4:0]    s_sa, s_dest;
  logic          s_valid, s_hold, s_hazard;
  logic [3:0]    s_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;
  int exp_sat  = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.CTRL_W(CW), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_instr(id_instr),
    .id_pc(id_pc), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
    .ext_stall(ext_stall), .flush(flush), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc),
    .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_imm16(ex_imm16),
    .ex_sa(ex_sa), .ex_dest(ex_dest), .ex_valid(ex_valid),
    .ifid_hold(ifid_hold), .hazard(hazard), .bubble_count(bubble_count)
  );

  id_ex_stage #(.CTRL_W(CW), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_instr(id_instr),
    .id_pc(id_pc), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
    .ext_stall(ext_stall), .flush(flush), .ex_ctrl(s_ctrl), .ex_pc(s_pc),
    .ex_rs_val(s_rs_val), .ex_rt_val(s_rt_val), .ex_imm16(s_imm16),
    .ex_sa(s_sa), .ex_dest(s_dest), .ex_valid(s_valid),
    .ifid_hold(s_hold), .hazard(s_hazard), .bubble_count(s_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic drive(input logic [CW-1:0] c, input logic [31:0] ins, input logic [31:0] pc);
    id_ctrl   = c;
    id_instr  = ins;
    id_pc     = pc;
    id_rs_val = pc ^ 32'hA5A5_0000;
    id_rt_val = pc ^ 32'h0000_5A5A;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Retire one hazard bubble in the model counters.
  task automatic count_bubble();
    exp_cnt++;
    if (exp_sat != 15) exp_sat++;
  endtask

  initial begin
    rst_n = 1'b0; ext_stall = 1'b0; flush = 1'b0;
    drive('0, '0, '0);
    #12;
    check("reset_valid", 32'(ex_valid), 32'd0);
    check("reset_count", 32'(bubble_count), 32'd0);
    rst_n = 1'b1;

    // Normal capture
    drive(C_ADDIU, I_ADDIU_R5, 32'h40);
    step();
    check("addiu_valid", 32'(ex_valid), 32'd1);
    check("addiu_dest", 32'(ex_dest), 32'd5);
    check("addiu_imm", 32'(ex_imm16), 32'h0010);
    check("addiu_pc", ex_pc, 32'h40);
    check("addiu_ctrl", 32'(ex_ctrl), 32'(C_ADDIU));
    check("addiu_rs", ex_rs_val, 32'hA5A5_0040);
    check("addiu_rt", ex_rt_val, 32'h0000_5A1A);

    drive(C_SUBU, I_SLL_R3, 32'h44);
    step();
    check("sll_sa", 32'(ex_sa), 32'd5);
    check("sll_dest", 32'(ex_dest), 32'd3);

    // Load-use: lbu r3 then subu using r3
    drive(C_LBU, I_LBU_R3, 32'h48);
    step();
    check("lbu_dest", 32'(ex_dest), 32'd3);
    drive(C_SUBU, I_SUBU_R4, 32'h4C);
    #1;
    check("lu_hazard", 32'(hazard), 32'd1);
    check("lu_hold", 32'(ifid_hold), 32'd1);
    step();
    count_bubble();
    check("lu_bubble_valid", 32'(ex_valid), 32'd0);
    check("lu_bubble_ctrl", 32'(ex_ctrl), 32'd0);
    check("lu_bubble_pc", ex_pc, 32'd0);
    check("lu_count", 32'(bubble_count), 32'(exp_cnt));
    check("lu_hazard_clear", 32'(hazard), 32'd0);
    check("lu_hold_clear", 32'(ifid_hold), 32'd0);
    step();
    check("lu_subu_valid", 32'(ex_valid), 32'd1);
    check("lu_subu_pc", ex_pc, 32'h4C);
    check("lu_subu_dest", 32'(ex_dest), 32'd4);

    // No false hazard: load into r0
    drive(C_LBU, I_LBU_R0, 32'h50);
    step();
    drive(C_SUBU, I_SUBU_R0, 32'h54);
    #1;
    check("r0_no_hazard", 32'(hazard), 32'd0);
    step();
    check("r0_capture", ex_pc, 32'h54);

    // No false hazard: rt field is a destination, not a source
    drive(C_LBU, I_LBU_R3, 32'h58);
    step();
    drive(C_ADDIU, I_ADDIU_R3, 32'h5C);
    #1;
    check("addiu_rt_no_hazard", 32'(hazard), 32'd0);
    step();
    check("addiu_rt_capture", ex_pc, 32'h5C);

    // SB reads rt; hazard present but flush wins and nothing is counted
    drive(C_LBU, I_LBU_R3, 32'h60);
    step();
    drive(C_SB, I_SB_R3, 32'h64);
    flush = 1'b1;
    #1;
    check("sb_hazard", 32'(hazard), 32'd1);
    check("sb_flush_hold", 32'(ifid_hold), 32'd0);
    step();
    flush = 1'b0;
    check("sb_flush_valid", 32'(ex_valid), 32'd0);
    check("sb_flush_count", 32'(bubble_count), 32'(exp_cnt));

    // JAL links r31
    drive(C_JAL, I_JAL, 32'h68);
    step();
    check("jal_dest", 32'(ex_dest), 32'd31);

    // Freeze dominates flush for 3 cycles, then flush takes effect
    drive(C_ADDIU, I_ADDIU_R5, 32'h70);
    ext_stall = 1'b1;
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_hold", 32'(ifid_hold), 32'd1);
      step();
      check("stall_pc", ex_pc, 32'h68);
      check("stall_valid", 32'(ex_valid), 32'd1);
      check("stall_ctrl", 32'(ex_ctrl), 32'(C_JAL));
    end
    ext_stall = 1'b0;
    step();
    flush = 1'b0;
    check("unstall_flush_valid", 32'(ex_valid), 32'd0);
    check("unstall_flush_pc", ex_pc, 32'd0);

    // 20 load-use bubbles: 16-bit counter keeps counting, 4-bit one saturates
    for (int i = 0; i < 20; i++) begin
      drive(C_LBU, I_LBU_R3, 32'h100 + 32'(i) * 16);
      step();
      drive(C_SUBU, I_SUBU_R4, 32'h104 + 32'(i) * 16);
      step();
      count_bubble();
      check("sat_count4", 32'(s_count), 32'(exp_sat));
      step();
    end
    check("sat_count16", 32'(bubble_count), 32'(exp_cnt));
    check("sat_subu_valid", 32'(ex_valid), 32'd1);

    // Asynchronous reset in the middle of a cycle
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(ex_valid), 32'd0);
    check("async_pc", ex_pc, 32'd0);
    check("async_ctrl", 32'(ex_ctrl), 32'd0);
    check("async_count", 32'(bubble_count), 32'd0);
    step();
    #3;
    rst_n = 1'b1;
    drive(C_ADDIU, I_ADDIU_R5, 32'h80);
    step();
    check("post_reset_valid", 32'(ex_valid), 32'd1);
    check("post_reset_pc", ex_pc, 32'h80);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline stage between instruction decode and execute in the PPU.
- Each cycle it captures the 17-bit control word from the control unit, plus the decoded operands, immediate fields, PC and destination register.
- It detects load-use hazards against the instruction currently in EX. On a hazard it inserts a one-cycle bubble and holds the upstream IF/ID stage and PC.
- It supports external freeze (memory stall) and flush (bubble injection), and keeps a saturating count of hazard bubbles.

Parameters:
- CTRL_W, 17, control word width from the control unit.
- CNT_W, 16, width of the hazard-bubble counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_ctrl  in  CTRL_W  control word. Layout: [16:14] src-operand sel, [13:11] ALU op, [10] load, [9] RF enable, [8] branch, [7] jump-target, [6:5] mem size, [4] mem RW, [3] mem SE, [2] HI en, [1] LO en, [0] mem enable.
- id_instr  in  32  instruction in ID.
- id_pc  in  32  PC of the ID instruction.
- id_rs_val  in  32  register-file read of rs.
- id_rt_val  in  32  register-file read of rt.
- ext_stall  in  1  downstream freeze request.
- flush  in  1  kill the ID instruction; inject a bubble.
- ex_ctrl  out  CTRL_W  registered control word.
- ex_pc  out  32  registered PC.
- ex_rs_val  out  32  registered rs operand.
- ex_rt_val  out  32  registered rt operand.
- ex_imm16  out  16  registered instr[15:0].
- ex_sa  out  5  registered instr[10:6].
- ex_dest  out  5  registered destination register.
- ex_valid  out  1  EX holds a real instruction.
- ifid_hold  out  1  combinational; hold PC and IF/ID this cycle.
- hazard  out  1  combinational load-use hazard detect.
- bubble_count  out  CNT_W  saturating count of hazard bubbles.

Behaviour:
- Reset (rst_n low, asynchronous): all registered outputs are 0, including ex_valid=0 and bubble_count=0. Reset mid-operation discards the EX contents immediately.
- Destination decode, from id_instr[31:26]:
  - 000000 (R-type): instr[15:11].
  - 000011 (JAL): 5'd31.
  - all other opcodes: instr[20:16].
- ID uses rs: always. ID uses rt: opcode 000000 or 101000 (SB) only.
- hazard = ex_valid & ex_ctrl[10] & (ex_dest != 0) & ((ex_dest == instr[25:21]) | (uses_rt & ex_dest == instr[20:16])).
- ifid_hold = ext_stall | (hazard & ~flush).
- Per-edge update priority (highest first):
  1. ext_stall=1: every EX register holds its value. flush and hazard are ignored that cycle; upstream keeps flush asserted until a cycle with ext_stall=0.
  2. flush=1: bubble.
  3. hazard=1: bubble, and bubble_count increments unless it is all-ones (saturate, no wrap).
  4. Otherwise: capture all id_* fields and set ex_valid=1.
- Bubble: ex_ctrl=0, ex_valid=0, and ex_pc, ex_rs_val, ex_rt_val, ex_imm16, ex_sa, ex_dest are all 0.
- A load-use hazard costs exactly one bubble. After the bubble, ex_valid=0, so hazard deasserts and the held instruction is captured on the next edge.
- An all-zero instruction (NOP) with ctrl=0 is captured as valid (ex_valid=1). Destination is 0, so it can never raise a hazard.
- Latency: ID to EX is one cycle. No combinational path from id_* to ex_* outputs.
- Branch delay slot is architectural: a taken branch or jump does not flush by itself. flush is driven only by the exception/redirect logic.

Decomposition:
- Shared package, ppu_pkg:
  - control-word bit-index constants (CTRL_LOAD=10, CTRL_RF_EN=9, …).
  - opcode constants R_TYPE, JAL_OP, SB_OP, LBU_OP.
  - CTRL_W.
- One sub-module: load_use_detect. Purely combinational: dest/uses_rt decode plus the hazard compare. It is reused by the future EX/MEM forwarding unit.
- Pipeline registers and the counter live in id_ex_stage.

Test Plan:
- Reset: hold rst_n=0 mid-stream with ex_valid=1 -> all outputs 0 without waiting for a clock edge; after release, first capture occurs on the next edge.
- Normal capture: ADDIU r5,r1,0x0010 at pc=0x40 -> next cycle ex_valid=1, ex_dest=5, ex_imm16=0x0010, ex_pc=0x40, ex_ctrl equals the id_ctrl value.
- Load-use: LBU r3,0(r1) followed by SUBU r4,r3,r2 -> hazard=1 and ifid_hold=1 for exactly one cycle; EX shows a bubble (ex_valid=0, ex_ctrl=0); SUBU enters EX the following cycle; bubble_count=1.
- No false hazard: LBU r0,0(r1) then SUBU r4,r0,r2 -> no hazard. LBU r3 then ADDIU r3,r7,1 (rt unused as source) -> no hazard.
- Freeze vs flush: ext_stall=1 for 3 cycles with flush=1 -> EX registers unchanged for all 3 cycles. On the first cycle with ext_stall=0 -> bubble captured.
- Saturation: preload bubble_count near max (CNT_W=4 build) and force 20 hazards -> count stops at 15 and never wraps.
